// File: rtl/vedic_nbit_pipe_mult.sv
// Pipelined WIDTH x WIDTH Urdhva-Tiryakbhyam multiplier with signed/unsigned mode,
// valid/ready handshakes and a pass-through tag; three registered stages.

module vedic_mult #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W <= 4) begin : g_cell
    // Vertical/crosswise column sums: column k gathers every a[i]&b[j] with i+j==k.
    logic [2*W-1:0] col;
    always_comb begin
      p   = '0;
      col = '0;
      for (int unsigned k = 0; k < 2*W-1; k++) begin
        col = '0;
        for (int unsigned i = 0; i < W; i++) begin
          for (int unsigned j = 0; j < W; j++) begin
            if (i + j == k) col = col + {{(2*W-1){1'b0}}, a[i] & b[j]};
          end
        end
        p = p + (col << k);
      end
    end
  end else begin : g_split
    localparam int unsigned H = W / 2;
    logic [W-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
    logic [W:0]   mid;

    vedic_mult #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pp_ll));
    vedic_mult #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(pp_hl));
    vedic_mult #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(pp_lh));
    vedic_mult #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(pp_hh));

    assign mid = {1'b0, pp_hl} + {1'b0, pp_lh};
    assign p   = {pp_hh, pp_ll} + ({{(W-1){1'b0}}, mid} << H);
  end
endmodule

module vedic_nbit_pipe_mult #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int unsigned H = WIDTH / 2;

  logic advance;

  // S0: magnitudes and result sign
  logic             v0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg0;
  logic [TAG_W-1:0] tag0;

  // S1: registered half-width partial products
  logic             v1;
  logic [WIDTH-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [WIDTH-1:0] c_ll, c_hl, c_lh, c_hh;
  logic             neg1;
  logic [TAG_W-1:0] tag1;

  // S2: combine and apply sign
  logic [WIDTH:0]     mid;
  logic [2*WIDTH-1:0] mag_sum;
  logic [2*WIDTH-1:0] result;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  vedic_mult #(.W(H)) u_ll (.a(a_mag[H-1:0]),     .b(b_mag[H-1:0]),     .p(c_ll));
  vedic_mult #(.W(H)) u_hl (.a(a_mag[WIDTH-1:H]), .b(b_mag[H-1:0]),     .p(c_hl));
  vedic_mult #(.W(H)) u_lh (.a(a_mag[H-1:0]),     .b(b_mag[WIDTH-1:H]), .p(c_lh));
  vedic_mult #(.W(H)) u_hh (.a(a_mag[WIDTH-1:H]), .b(b_mag[WIDTH-1:H]), .p(c_hh));

  always_comb begin
    mid     = {1'b0, pp_hl} + {1'b0, pp_lh};
    mag_sum = {pp_hh, pp_ll} + ({{(WIDTH-1){1'b0}}, mid} << H);
    result  = mag_sum;
    // A zero magnitude stays zero regardless of the requested sign.
    if (neg1 && (mag_sum != '0)) result = -mag_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      v0        <= in_valid;
      v1        <= v0;
      out_valid <= v1;
      if (v1) begin
        out_p   <= result;
        out_tag <= tag1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      if (in_valid) begin
        a_mag <= (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        b_mag <= (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        neg0  <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        tag0  <= in_tag;
      end
      pp_ll <= c_ll;
      pp_hl <= c_hl;
      pp_lh <= c_lh;
      pp_hh <= c_hh;
      neg1  <= neg0;
      tag1  <= tag0;
    end
  end
endmodule

// File: tb/tb_vedic_nbit_pipe_mult.sv
// Directed-vector and stream bench for vedic_nbit_pipe_mult (WIDTH=8 main instance,
// plus WIDTH=4/16/32 sweep instances).

module tb_vedic_nbit_pipe_mult;
  localparam int W = 8;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [W-1:0]   in_a, in_b;
  logic [T-1:0]   in_tag, out_tag;
  logic [2*W-1:0] out_p;
  logic           sweep_go = 1'b0;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vedic_nbit_pipe_mult #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference product in 2*w bits, independent of the Vedic decomposition.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input int w);
    logic [63:0] xa, xb, m;
    xa = {32'b0, a};
    xb = {32'b0, b};
    if (s && a[w-1]) xa = xa | (64'hFFFF_FFFF_FFFF_FFFF << w);
    if (s && b[w-1]) xb = xb | (64'hFFFF_FFFF_FFFF_FFFF << w);
    m = xa * xb;
    return m & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [T-1:0] tag, input logic [2*W-1:0] exp, input string name);
    int lat;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    check({name, "_ready"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_p"}, {48'b0, out_p}, {48'b0, exp});
    check({name, "_tag"}, {60'b0, out_tag}, {60'b0, tag});
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs[12];
  logic [W-1:0]   sa[16], sb[16];
  logic           ss[16];
  logic [2*W-1:0] sp[16];
  int             cnt, first, last, n, k;
  logic           acc;

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_p", {48'b0, out_p}, 64'd0);
    check("rst_out_tag", {60'b0, out_tag}, 64'd0);
    rst = 1'b0;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[4]  = '{8'hFD, 8'h07, 1'b1, 16'hFFEB};
    vecs[5]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
    vecs[8]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[9]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[10] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[11] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
    for (int i = 0; i < 12; i++)
      run_one(vecs[i].a, vecs[i].b, vecs[i].s, 4'(i), vecs[i].p, $sformatf("vec%0d", i));

    // Reset while three beats are in flight; none of them may emerge.
    in_a = 8'h11; in_b = 8'h22; in_signed = 1'b0; in_tag = 4'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h33; in_tag = 4'h2;
    @(posedge clk); #1;
    in_a = 8'h44; in_tag = 4'h3;
    #5 rst = 1'b1;
    #1 check("midrst_valid_async", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out_p", {48'b0, out_p}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midrst_quiet%0d", i), {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    run_one(8'h12, 8'h34, 1'b0, 4'h9, 16'h03A8, "after_rst");

    // Back-to-back stream of 16 beats.
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      ss[i] = 1'($urandom_range(0, 1));
      sp[i] = 16'(model({24'b0, sa[i]}, {24'b0, sb[i]}, ss[i], W));
    end
    cnt = 0; first = -1; last = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          in_a = sa[i]; in_b = sb[i]; in_signed = ss[i]; in_tag = 4'(i); in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && cnt < 16; c++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            check($sformatf("stream_p%0d", cnt), {48'b0, out_p}, {48'b0, sp[cnt]});
            check($sformatf("stream_tag%0d", cnt), {60'b0, out_tag}, 64'(cnt));
            if (first < 0) first = c;
            last = c;
            cnt++;
          end
        end
      end
    join
    check("stream_count", 64'(cnt), 64'd16);
    check("stream_consecutive", 64'(last - first), 64'd15);
    @(posedge clk); #1;

    // Back-pressure: out_ready low while the source keeps offering beats.
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      in_a = sa[n]; in_b = sb[n]; in_signed = ss[n]; in_tag = 4'(n + 3); in_valid = 1'b1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      if (c >= 2) begin
        check($sformatf("bp_hold_valid%0d", c), {63'b0, out_valid}, 64'd1);
        check($sformatf("bp_hold_p%0d", c), {48'b0, out_p}, {48'b0, sp[0]});
        check($sformatf("bp_hold_tag%0d", c), {60'b0, out_tag}, 64'd3);
        check($sformatf("bp_in_ready%0d", c), {63'b0, in_ready}, 64'd0);
      end
    end
    check("bp_accepted", 64'(n), 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      if (out_valid) begin
        check($sformatf("bp_drain_p%0d", k), {48'b0, out_p}, {48'b0, sp[k]});
        check($sformatf("bp_drain_tag%0d", k), {60'b0, out_tag}, 64'(k + 3));
        k++;
      end
      @(posedge clk); #1;
    end
    check("bp_drain_count", 64'(k), 64'd3);
    check("bp_no_duplicate", {63'b0, out_valid}, 64'd0);

    sweep_go = 1'b1;
    for (int c = 0; c < 5000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); c++)
      @(posedge clk);
    check("sweep_complete",
          {61'b0, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 64'd7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 4 : ((gi == 1) ? 16 : 32);
    localparam int SN = (gi == 0) ? 512 : 300;

    logic            xv, xr, xs, xov, xor_ready;
    logic [SW-1:0]   xa, xb;
    logic [0:0]      xt, xot;
    logic [2*SW-1:0] xp;
    logic            done = 1'b0;
    logic [63:0]     q[$];
    int              got;

    assign xor_ready = 1'b1;

    vedic_nbit_pipe_mult #(.WIDTH(SW), .TAG_W(1)) u_sweep (
      .clk(clk), .rst(rst),
      .in_valid(xv), .in_ready(xr),
      .in_a(xa), .in_b(xb), .in_signed(xs), .in_tag(xt),
      .out_valid(xov), .out_ready(xor_ready),
      .out_p(xp), .out_tag(xot)
    );

    initial begin
      xv = 1'b0; xa = '0; xb = '0; xs = 1'b0; xt = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      got = 0;
      fork
        begin
          for (int i = 0; i < SN; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            if (SW == 4) begin
              xa = SW'(iv[3:0]);
              xb = SW'(iv[7:4]);
              xs = iv[8];
            end else if (i < 4) begin
              xa = iv[0] ? '1 : {1'b1, {(SW-1){1'b0}}};
              xb = xa;
              xs = iv[1];
            end else begin
              xa = SW'($urandom);
              xb = SW'($urandom);
              xs = 1'($urandom_range(0, 1));
            end
            xt = iv[0:0];
            xv = 1'b1;
            q.push_back(model(32'(xa), 32'(xb), xs, SW));
            @(posedge clk); #1;
          end
          xv = 1'b0;
        end
        begin
          for (int c = 0; c < SN + 20 && got < SN; c++) begin
            @(posedge clk); #1;
            if (xov) begin
              if (q.size() == 0) check($sformatf("sweep_w%0d_extra", SW), 64'd1, 64'd0);
              else check($sformatf("sweep_w%0d_p%0d", SW, got), 64'(xp), q.pop_front());
              got++;
            end
          end
        end
      join
      check($sformatf("sweep_w%0d_count", SW), 64'(got), 64'(SN));
      done = 1'b1;
    end
  end
endmodule
